// File: rtl/param_universal_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : param_universal_shift_reg
// Description : WIDTH-bit universal shift register (hold / load / logical
//               shift right / shift left / rotate right / rotate left /
//               arithmetic shift right) with a start/busy/done burst engine
//               that repeats one operation a programmed number of times.
// Ports       : clk, reset       - clock, synchronous active-high reset
//               mode[2:0]        - operation select
//               start, amount    - burst request and burst length
//               d_parallel       - parallel load data
//               d_series_r/_l    - serial inputs (MSB on right shift,
//                                  LSB on left shift)
//               q, so_r, so_l    - register contents and serial outputs
//               busy, done       - burst in progress / burst complete pulse
//               q_parity         - registered XOR of q (USR_PARITY_EN only)
// Config      : define USR_PARITY_EN to add the q_parity output.
// Revision    : 1.0 - initial release
// ============================================================================
module param_universal_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       mode,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] d_parallel,
  input  logic             d_series_r,
  input  logic             d_series_l,
  output logic [WIDTH-1:0] q,
  output logic             so_r,
  output logic             so_l,
  output logic             busy,
  output logic             done
`ifdef USR_PARITY_EN
  ,
  output logic             q_parity
`endif
);

  localparam logic [2:0] c_MODE_HOLD = 3'b000;
  localparam logic [2:0] c_MODE_LOAD = 3'b001;
  localparam logic [2:0] c_MODE_LSR  = 3'b010;
  localparam logic [2:0] c_MODE_SL   = 3'b011;
  localparam logic [2:0] c_MODE_ROR  = 3'b100;
  localparam logic [2:0] c_MODE_ROL  = 3'b101;
  localparam logic [2:0] c_MODE_ASR  = 3'b110;

  localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       mode_lat_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             done_q;

  logic [2:0]       w_op;
  logic             w_zero_start;
  logic [WIDTH-1:0] w_shifted;

  // Datapath next state. During a burst the latched mode drives the
  // operation; in IDLE the live mode input does (direct mode and the
  // first shift of a burst share this path).
  always_comb begin
    w_op         = (state_q == ST_RUN) ? mode_lat_q : mode;
    // A zero-length burst must leave q untouched, even for a load mode.
    w_zero_start = (state_q == ST_IDLE) && start && (amount == c_CNT_ZERO);
    w_shifted    = q_q;
    case (w_op)
      c_MODE_HOLD: w_shifted = q_q;
      c_MODE_LOAD: w_shifted = d_parallel;
      c_MODE_LSR:  w_shifted = {d_series_r, q_q[WIDTH-1:1]};
      c_MODE_SL:   w_shifted = {q_q[WIDTH-2:0], d_series_l};
      c_MODE_ROR:  w_shifted = {q_q[0], q_q[WIDTH-1:1]};
      c_MODE_ROL:  w_shifted = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      c_MODE_ASR:  w_shifted = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
      default:     w_shifted = q_q;
    endcase
    q_d = w_zero_start ? q_q : w_shifted;
  end

`ifdef USR_PARITY_EN
  logic q_parity_q;
`endif

  // Burst controller plus state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      mode_lat_q <= c_MODE_HOLD;
      q_q        <= '0;
      done_q     <= 1'b0;
`ifdef USR_PARITY_EN
      q_parity_q <= 1'b0;
`endif
    end else begin
      q_q <= q_d;
`ifdef USR_PARITY_EN
      // Parity of the next-state value so it lines up with q every cycle.
      q_parity_q <= ^q_d;
`endif
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            if (amount == c_CNT_ZERO) begin
              done_q <= 1'b1;
            end else begin
              mode_lat_q <= mode;
              if (amount == c_CNT_ONE) begin
                // Single shift completes in the start edge itself.
                done_q <= 1'b1;
              end else begin
                // First shift already happened on this edge.
                cnt_q   <= amount - c_CNT_ONE;
                state_q <= ST_RUN;
              end
            end
          end
        end
        ST_RUN: begin
          cnt_q <= cnt_q - c_CNT_ONE;
          if (cnt_q == c_CNT_ONE) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end else begin
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign q    = q_q;
  assign so_r = q_q[0];
  assign so_l = q_q[WIDTH-1];
  assign busy = (state_q == ST_RUN);
  assign done = done_q;
`ifdef USR_PARITY_EN
  assign q_parity = q_parity_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_param_universal_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_universal_shift_reg
// Description : Self-checking bench for param_universal_shift_reg (WIDTH=8).
//               A behavioural model pushes the expected q/busy/done into a
//               scoreboard queue as each cycle of stimulus is driven; the
//               entry is popped and compared after the corresponding edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_universal_shift_reg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       mode;
  logic             start;
  logic [CNT_W-1:0] amount;
  logic [WIDTH-1:0] d_parallel;
  logic             d_series_r;
  logic             d_series_l;
  logic [WIDTH-1:0] q;
  logic             so_r;
  logic             so_l;
  logic             busy;
  logic             done;
`ifdef USR_PARITY_EN
  logic             q_parity;
`endif

  always #5 clk = ~clk;

  param_universal_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    .start      (start),
    .amount     (amount),
    .d_parallel (d_parallel),
    .d_series_r (d_series_r),
    .d_series_l (d_series_l),
    .q          (q),
    .so_r       (so_r),
    .so_l       (so_l),
    .busy       (busy),
    .done       (done)
`ifdef USR_PARITY_EN
    ,
    .q_parity   (q_parity)
`endif
  );

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state.
  logic [WIDTH-1:0] m_q    = '0;
  logic             m_busy = 1'b0;
  logic             m_done = 1'b0;
  int               m_cnt  = 0;
  logic [2:0]       m_mode = 3'b000;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] md, input logic [WIDTH-1:0] v,
                                              input logic [WIDTH-1:0] dp, input logic sr,
                                              input logic sl);
    case (md)
      3'b001:  return dp;
      3'b010:  return (v >> 1) | (WIDTH'(sr) << (WIDTH-1));
      3'b011:  return (v << 1) | WIDTH'(sl);
      3'b100:  return (v >> 1) | (WIDTH'(v[0]) << (WIDTH-1));
      3'b101:  return (v << 1) | WIDTH'(v[WIDTH-1]);
      3'b110:  return (v >> 1) | (WIDTH'(v[WIDTH-1]) << (WIDTH-1));
      default: return v;
    endcase
  endfunction

  // One clock: model the edge from the current inputs, queue the
  // expectation, let the DUT take the edge, then compare.
  task automatic step(input string tag);
    exp_t e;
    if (reset) begin
      m_q = '0; m_busy = 1'b0; m_done = 1'b0; m_cnt = 0; m_mode = 3'b000;
    end else if (!m_busy) begin
      m_done = 1'b0;
      if (!start) begin
        m_q = ref_op(mode, m_q, d_parallel, d_series_r, d_series_l);
      end else if (amount == 0) begin
        m_done = 1'b1;
      end else begin
        m_q    = ref_op(mode, m_q, d_parallel, d_series_r, d_series_l);
        m_mode = mode;
        if (amount == 1) m_done = 1'b1;
        else begin
          m_cnt  = int'(amount) - 1;
          m_busy = 1'b1;
        end
      end
    end else begin
      m_q   = ref_op(m_mode, m_q, d_parallel, d_series_r, d_series_l);
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end else begin
        m_done = 1'b0;
      end
    end
    sb_q.push_back('{q: m_q, busy: m_busy, done: m_done});

    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_val({tag, "_q"},    32'(q),    32'(e.q));
      check_val({tag, "_busy"}, 32'(busy), 32'(e.busy));
      check_val({tag, "_done"}, 32'(done), 32'(e.done));
      check_val({tag, "_so_r"}, 32'(so_r), 32'(e.q[0]));
      check_val({tag, "_so_l"}, 32'(so_l), 32'(e.q[WIDTH-1]));
      check_val({tag, "_nooverlap"}, 32'(busy & done), 32'd0);
`ifdef USR_PARITY_EN
      check_val({tag, "_parity"}, 32'(q_parity), 32'(^e.q));
`endif
    end
  endtask

  task automatic drive(input logic [2:0] md, input logic st, input logic [CNT_W-1:0] amt,
                       input logic [WIDTH-1:0] dp, input logic sr, input logic sl);
    mode = md; start = st; amount = amt; d_parallel = dp; d_series_r = sr; d_series_l = sl;
  endtask

  initial begin
    reset = 1'b1;
    drive(3'($urandom), 1'b1, 4'($urandom), 8'($urandom), 1'b1, 1'b1);

    // Reset with arbitrary inputs for two edges.
    step("rst0");
    drive(3'($urandom), 1'b1, 4'($urandom), 8'($urandom), 1'b1, 1'b1);
    step("rst1");
    check_val("rst_q", 32'(q), 32'h00);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    reset = 1'b0;

    // Direct load then rotate right.
    drive(3'b001, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0);
    step("load_a5");
    check_val("load_a5_const", 32'(q), 32'hA5);
    drive(3'b100, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    step("ror");
    check_val("ror_const", 32'(q), 32'hD2);
    // Direct rotate left and shift modes.
    drive(3'b101, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    step("rol");
    drive(3'b011, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1);
    step("sl_direct");
    drive(3'b010, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0);
    step("lsr_direct");
    drive(3'b111, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    step("reserved_hold");

    // Arithmetic burst of 3.
    drive(3'b001, 1'b0, 4'd0, 8'h81, 1'b0, 1'b0);
    step("load_81");
    drive(3'b110, 1'b1, 4'd3, 8'h00, 1'b0, 1'b0);
    step("asr_b0");
    check_val("asr_busy1", 32'(busy), 32'd1);
    drive(3'b001, 1'b0, 4'd0, 8'h55, 1'b0, 1'b0);
    step("asr_b1");
    check_val("asr_busy2", 32'(busy), 32'd1);
    step("asr_b2");
    check_val("asr_final", 32'(q), 32'hF0);
    check_val("asr_done", 32'(done), 32'd1);

    // Long left burst, mode toggled during RUN.
    drive(3'b001, 1'b0, 4'd0, 8'h01, 1'b0, 1'b0);
    step("load_01");
    drive(3'b011, 1'b1, 4'd8, 8'h00, 1'b0, 1'b1);
    step("sl_b0");
    for (int i = 1; i < 8; i++) begin
      drive(3'($urandom), 1'($urandom), 4'($urandom), 8'($urandom), 1'b0, 1'b1);
      step("sl_run");
    end
    check_val("sl_final", 32'(q), 32'hFF);
    check_val("sl_done", 32'(done), 32'd1);

    // Zero-length burst presented in the done cycle.
    drive(3'b001, 1'b1, 4'd0, 8'h3C, 1'b0, 1'b0);
    step("zero_start");
    check_val("zero_q", 32'(q), 32'hFF);
    check_val("zero_done", 32'(done), 32'd1);
    // Burst of 4 with a start pulse mid-burst that must be ignored.
    drive(3'b100, 1'b1, 4'd4, 8'h00, 1'b0, 1'b0);
    step("ror4_b0");
    drive(3'b000, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    step("ror4_b1");
    drive(3'b001, 1'b1, 4'd1, 8'h99, 1'b0, 1'b0);
    step("ror4_b2");
    check_val("ror4_still_busy", 32'(busy), 32'd1);
    drive(3'b000, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    step("ror4_b3");
    check_val("ror4_done", 32'(done), 32'd1);
    step("after_done");
    check_val("done_pulse_once", 32'(done), 32'd0);

    // Amount above WIDTH flushes the register with serial input.
    drive(3'b010, 1'b1, 4'd10, 8'h00, 1'b1, 1'b0);
    step("flush_b0");
    for (int i = 1; i < 10; i++) begin
      drive(3'b000, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0);
      step("flush_run");
    end
    check_val("flush_q", 32'(q), 32'hFF);
    check_val("flush_done", 32'(done), 32'd1);

    // Reset mid-burst.
    drive(3'b001, 1'b0, 4'd0, 8'hF0, 1'b0, 1'b0);
    step("load_f0");
    drive(3'b010, 1'b1, 4'd5, 8'h00, 1'b0, 1'b0);
    step("lsr5_b0");
    drive(3'b000, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    step("lsr5_b1");
    step("lsr5_b2");
    check_val("lsr5_mid_q", 32'(q), 32'h1E);
    reset = 1'b1;
    step("mid_rst");
    check_val("mid_rst_q", 32'(q), 32'h00);
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    step("post_rst0");
    check_val("post_rst_no_done", 32'(done), 32'd0);
    step("post_rst1");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/param_universal_shift_reg.md
# param_universal_shift_reg

Parametrised universal shift register with a burst-shift engine. It generalises the 4-bit hold/load/shift-right/shift-left register to WIDTH bits and adds rotate and arithmetic-shift modes. A start/busy/done handshake lets it perform a programmed number of shifts autonomously. It sits in the shift-register library as the general-purpose serialiser/deserialiser and barrel-by-iteration element.

## Interface
Parameters:
- WIDTH, 8, register width in bits (≥2).
- CNT_W, $clog2(WIDTH)+1, width of the burst amount field (holds 0..WIDTH at minimum).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- mode  input  3  operation select, see Operation.
- start  input  1  request a burst of `amount` operations in `mode`.
- amount  input  CNT_W  burst length, sampled with start.
- d_parallel  input  WIDTH  parallel load data.
- d_series_r  input  1  serial input entering at MSB on logical right shift.
- d_series_l  input  1  serial input entering at LSB on left shift.
- q  output  WIDTH  register contents (parallel output).
- so_r  output  1  q[0], combinational from q.
- so_l  output  1  q[WIDTH-1], combinational from q.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse when a burst completes.

## Operation
- Modes: 000 hold; 001 load d_parallel; 010 logical shift right, MSB ← d_series_r; 011 shift left, LSB ← d_series_l; 100 rotate right; 101 rotate left; 110 arithmetic shift right, MSB replicated; 111 hold (reserved).
- Reset has priority over everything: q=0, busy=0, done=0, internal counter=0, latched mode=000.
- States: IDLE (busy=0) and RUN (busy=1).
- IDLE, start=0: the `mode` operation is applied on every edge (direct mode). done=0.
- IDLE, start=1, amount=0: q is unchanged and done=1 for one cycle.
- IDLE, start=1, amount≥1: shift #1 is performed in the start edge and mode is latched.
  - amount=1: stay in IDLE, done=1.
  - Otherwise: counter=amount−1, enter RUN.
- Modes 000, 001 and 111 inside a burst: the operation is applied once per burst edge; load repeats identically.
- RUN: on each edge, apply the latched mode and decrement the counter.
  - On the edge where the counter goes 1→0: return to IDLE, busy=0, done=1.
  - mode, start and amount inputs are ignored during RUN.
  - d_series_r and d_series_l are sampled live on every edge.
- start while busy=1 is ignored and is not queued.
- amount values above WIDTH execute literally; e.g. a logical shift flushes the register completely with serial input.

## Timing
- Direct operations: q updates on the edge the mode is sampled (latency 1 clock).
- Burst of N≥1: q holds the final value after exactly N edges, counting the start edge.
  - busy is high for N−1 cycles.
  - done is high in the same cycle the final q is visible.
- Burst of 0: done is high in the cycle after the start edge.
- done never overlaps busy=1.
- Next burst: a new start may be presented in the done cycle and is accepted.
- Reset mid-burst: the burst is aborted with no done pulse; busy=0 on the next cycle.
- so_r and so_l follow q with no extra register.

## Configuration
- USR_PARITY_EN defined: adds output port q_parity (1 bit).
  - q_parity is registered and equals XOR of the next-state q, so it always matches ^q in the same cycle.
  - Reset value is 0.
- USR_PARITY_EN undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
All scenarios use WIDTH=8.
- Reset: hold reset 2 edges with arbitrary inputs → q=0x00, busy=0, done=0, so_r=0, so_l=0.
- Direct rotate: mode=001 with d_parallel=0xA5 → q=0xA5 after 1 edge; then mode=100 for 1 edge → q=0xD2.
- Arithmetic burst: load 0x81, then start with mode=110, amount=3 → busy=1 for 2 cycles; third cycle q=0xF0, done=1, busy=0.
- Long left burst: load 0x01, then start with mode=011, amount=8, d_series_l=1; toggle the mode input during RUN → mode changes are ignored; after 8 edges q=0xFF, done=1.
- Zero and overlapping starts: start with amount=0 → q unchanged, done=1 for one cycle; start pulsed during a running burst → ignored, total burst length unchanged.
- Reset mid-burst: load 0xF0, start mode=010, amount=5, assert reset after the 3rd edge → q=0x00, busy=0, no done pulse; with USR_PARITY_EN, q_parity tracks ^q throughout.
